// File: rtl/unfill_111to101_pkg.sv
// Shared types and constants for the 111->101 unfill decoder.
// Optional PATTERN_CHECK_EN adds a 101-pattern error flag to the result.
package unfill_111to101_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 16;

    // Count width; also wide enough to hold the scan pointer (max WIDTH-1).
    function automatic int cw_of(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/unfill_111to101_if.sv
// Word-in / result-out handshake bundle for unfill_111to101.
// out_err exists only when PATTERN_CHECK_EN is defined.
interface unfill_111to101_if
    import unfill_111to101_pkg::*;
#(
    parameter int WIDTH = 6
);
    localparam int CW = cw_of(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_cnt;
`ifdef PATTERN_CHECK_EN
    logic             out_err;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
`ifdef PATTERN_CHECK_EN
        , input out_err
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_cnt
`ifdef PATTERN_CHECK_EN
        , output out_err
`endif
    );

endinterface

// File: rtl/unfill_111to101_win3_clear.sv
// One 3-bit window step: a 111 window gets its middle bit cleared.
module win3_clear (
    input  logic [2:0] i_win,
    output logic [2:0] o_win,
    output logic       o_clr
);
    assign o_clr = (i_win == 3'b111);
    assign o_win = o_clr ? 3'b101 : i_win;
endmodule

// File: rtl/unfill_111to101.sv
// Sequential 111->101 decoder: scans one 3-bit window per clock, MSB to LSB.
// Define PATTERN_CHECK_EN to flag input words containing an illegal 101.
module unfill_111to101
    import unfill_111to101_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    unfill_111to101_if.slave bus
);
    localparam int CW = cw_of(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_out_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CW-1:0]    w_sh;
    logic [2:0]       w_win;
    logic [2:0]       w_win_new;
    logic             w_clr;
    logic [WIDTH-1:0] w_work_upd;
    logic [CW-1:0]    w_cnt_upd;

    // Window LSB sits at ptr-2; shifting avoids out-of-range part selects.
    always_comb begin
        w_sh       = r_ptr - CW'(2);
        w_win      = 3'(r_work >> w_sh);
        w_work_upd = (r_work & ~(WIDTH'(3'b111) << w_sh)) | (WIDTH'(w_win_new) << w_sh);
        w_cnt_upd  = r_cnt + {{(CW-1){1'b0}}, w_clr};
    end

    win3_clear u_win (
        .i_win (w_win),
        .o_win (w_win_new),
        .o_clr (w_clr)
    );

`ifdef PATTERN_CHECK_EN
    logic r_err;
    logic r_out_err;
    logic w_in_err;

    always_comb begin
        w_in_err = 1'b0;
        for (int k = 2; k < WIDTH; k++)
            if (bus.in_data[k -: 3] == 3'b101) w_in_err = 1'b1;
    end

    assign bus.out_err = r_out_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef PATTERN_CHECK_EN
            r_err       <= 1'b0;
            r_out_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_work     <= bus.in_data;
                    r_ptr      <= CW'(WIDTH - 1);
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                    r_state    <= SCAN;
`ifdef PATTERN_CHECK_EN
                    r_err      <= w_in_err;
`endif
                end
                SCAN: begin
                    r_work <= w_work_upd;
                    r_cnt  <= w_cnt_upd;
                    if (r_ptr == CW'(2)) begin
                        r_out_data  <= w_work_upd;
                        r_out_cnt   <= w_cnt_upd;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef PATTERN_CHECK_EN
                        r_out_err   <= r_err;
`endif
                    end else begin
                        r_ptr <= r_ptr - CW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_unfill_111to101.sv
// Self-checking bench for unfill_111to101 (WIDTH=6): vector table, corner
// sequences and random words against a rule-level reference model.
module tb_unfill_111to101;
    import unfill_111to101_pkg::*;

    localparam int W  = 6;
    localparam int CW = cw_of(W);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unfill_111to101_if #(.WIDTH(W)) bus();
    unfill_111to101 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        int           cnt;
        logic         err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: apply the window rule to a working copy, MSB window first.
    function automatic void model(input logic [W-1:0] d, output logic [W-1:0] o,
                                  output int c, output logic e);
        o = d; c = 0; e = 1'b0;
        for (int k = W - 1; k >= 2; k--) begin
            if (d[k] && !d[k-1] && d[k-2]) e = 1'b1;
            if (o[k] && o[k-1] && o[k-2]) begin
                o[k-1] = 1'b0;
                c++;
            end
        end
    endfunction

    function automatic logic get_err();
`ifdef PATTERN_CHECK_EN
        return bus.out_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_word(input logic [W-1:0] d, input int hold, input bit pulse,
                            output logic [W-1:0] od, output int oc,
                            output logic oe, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", int'(bus.out_valid), 1);
        od = bus.out_data;
        oc = int'(bus.out_cnt);
        oe = get_err();
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                bus.in_valid = 1'b1;
                bus.in_data  = ~d;
            end
            @(posedge clk); #1;
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_out_data", int'(bus.out_data), int'(od));
            chk("bp_out_cnt", int'(bus.out_cnt), oc);
            chk("bp_out_err", int'(get_err()), int'(oe));
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", int'(bus.in_ready), 1);
        chk("idle_out_valid", int'(bus.out_valid), 0);
        chk("idle_hold_data", int'(bus.out_data), int'(od));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [9];
        logic [W-1:0] od, ed;
        logic         oe, ee;
        int           oc, ec, lat;
        int           acc [2];
        logic [W-1:0] rd  [2];
        int           rc  [2];
        int           n_acc, n_res, seen;
        logic         pre;

        tbl[0] = '{6'b111000, 6'b101000, 1, 1'b0};
        tbl[1] = '{6'b111111, 6'b101011, 2, 1'b0};
        tbl[2] = '{6'b111110, 6'b101010, 2, 1'b0};
        tbl[3] = '{6'b000000, 6'b000000, 0, 1'b0};
        tbl[4] = '{6'b011100, 6'b010100, 1, 1'b0};
        tbl[5] = '{6'b101000, 6'b101000, 0, 1'b1};
        tbl[6] = '{6'b111011, 6'b101011, 1, 1'b1};
        tbl[7] = '{6'b001110, 6'b001010, 1, 1'b0};
        tbl[8] = '{6'b011111, 6'b010101, 2, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_cnt", int'(bus.out_cnt), 0);
        chk("rst_out_err", int'(get_err()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_word(tbl[i].din, 0, 1'b0, od, oc, oe, lat);
            chk($sformatf("tbl%0d_data", i), int'(od), int'(tbl[i].dout));
            chk($sformatf("tbl%0d_cnt", i), oc, tbl[i].cnt);
            chk($sformatf("tbl%0d_latency", i), lat, W - 2);
`ifdef PATTERN_CHECK_EN
            chk($sformatf("tbl%0d_err", i), int'(oe), int'(tbl[i].err));
`endif
        end

        // Back-pressure for 3 cycles with an ignored in_valid pulse.
        run_word(6'b111000, 3, 1'b1, od, oc, oe, lat);
        chk("bp_result_data", int'(od), 6'b101000);
        chk("bp_result_cnt", oc, 1);

        // Back-to-back with in_valid held.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b111000;
        n_acc = 0;
        n_res = 0;
        for (int c = 0; c < 30 && n_res < 2; c++) begin
            pre = bus.in_ready;
            @(posedge clk); #1;
            if (pre && bus.in_valid && n_acc < 2) begin
                acc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) bus.in_data = 6'b011100;
                else            bus.in_valid = 1'b0;
            end
            if (bus.out_valid && n_res < 2) begin
                rd[n_res] = bus.out_data;
                rc[n_res] = int'(bus.out_cnt);
                n_res++;
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_results", n_res, 2);
        if (n_acc == 2) chk("b2b_accept_gap", acc[1] - acc[0], 6);
        if (n_res == 2) begin
            chk("b2b_data0", int'(rd[0]), 6'b101000);
            chk("b2b_cnt0", rc[0], 1);
            chk("b2b_data1", int'(rd[1]), 6'b010100);
            chk("b2b_cnt1", rc[1], 1);
        end
        @(posedge clk); #1;

        // Reset during the 2nd SCAN cycle aborts the word.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b111111;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_out_data", int'(bus.out_data), 0);
        chk("abort_out_cnt", int'(bus.out_cnt), 0);
        chk("abort_out_err", int'(get_err()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        chk("abort_no_out_valid", seen, 0);
        run_word(6'b111110, 0, 1'b0, od, oc, oe, lat);
        chk("post_abort_data", int'(od), 6'b101010);
        chk("post_abort_cnt", oc, 2);

        // Random words with random back-pressure.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            model(d, ed, ec, ee);
            run_word(d, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), od, oc, oe, lat);
            chk($sformatf("rnd%0d_data", i), int'(od), int'(ed));
            chk($sformatf("rnd%0d_cnt", i), oc, ec);
            chk($sformatf("rnd%0d_latency", i), lat, W - 2);
`ifdef PATTERN_CHECK_EN
            chk($sformatf("rnd%0d_err", i), int'(oe), int'(ee));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unfill_111to101.md
# unfill_111to101

Sequential decoder for words produced by the gap-fill encoder (101 -> 111 substitution). It accepts one WIDTH-bit word per valid/ready handshake and scans three-bit windows one per clock, MSB to LSB. In the running working copy, every window equal to 111 has its middle bit cleared. It returns the result with a count of cleared bits. It sits on the receive side of the encoded-word path, between the word source and the consumer.

## Interface
- WIDTH, 6, word width in bits; legal range 3..16
- CW, $clog2(WIDTH), derived width of the count output; not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word offered
- in_ready  output  1  block can accept a word; high only in IDLE
- in_data  input  WIDTH  word to decode
- out_valid  output  1  result available; held until accepted
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  decoded word
- out_cnt  output  CW  number of middle bits cleared (0..WIDTH-2)
- out_err  output  1  present only with PATTERN_CHECK_EN; input contained 101

## Operation
- FSM states are IDLE, SCAN and DONE. The reset state is IDLE.
- **IDLE:** in_ready=1. On in_valid&&in_ready:
  - work <= in_data
  - ptr <= WIDTH-1
  - cnt <= 0
  - go to SCAN
- **SCAN:** each cycle, examine work[ptr:ptr-2] as already updated by earlier cycles.
  - If the window is 111: clear work[ptr-1] and increment cnt.
  - If ptr==2: load out_data <= updated work, out_cnt <= updated cnt, and go to DONE. Otherwise ptr <= ptr-1.
- **DONE:** out_valid=1.
  - On out_ready: go to IDLE.
  - A new word is not accepted in the same cycle; in_ready rises the next cycle.
- in_valid outside IDLE is ignored. in_data is sampled only at the accept edge.
- out_data and out_cnt change only on entry to DONE and hold their values through IDLE until the next DONE.
- Windows are evaluated strictly sequentially. A bit cleared in window ptr is visible to window ptr-1.
- The count saturates at no value: its maximum, WIDTH-2, always fits in CW bits.
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_data=0
  - out_cnt=0
  - out_err=0
  - internal work, ptr and cnt = 0
- Reset asserted mid-SCAN or in DONE aborts the word. The word is discarded and no output is produced.

## Timing
- Latency: out_valid goes high at the (WIDTH-2)th rising edge after the accept edge. With WIDTH=6 this is 4 edges.
- Minimum period between accepts is WIDTH cycles when out_ready is held high: 1 IDLE + (WIDTH-2) SCAN + 1 DONE.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.
- While out_valid=1 and out_ready=0, out_data, out_cnt and out_err are stable.

## Configuration
- Macro: PATTERN_CHECK_EN.
- **Defined:**
  - out_err port exists.
  - At the accept edge, err <= 1 if any in_data[k:k-2]==101 for k in WIDTH-1..2. A legal encoder output never contains 101.
  - out_err is loaded with err on DONE entry, and uses the same hold rules as out_data.
  - The decode result is unaffected by err.
- **Undefined:** no out_err port and no check logic. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, SCAN, DONE)
  - the WIDTH range constants
  - a function returning CW for a given WIDTH
- Optional sub-module win3_clear (combinational). Inputs: 3-bit window. Outputs: the updated window and a cleared flag. It is instantiated once and driven by the ptr-selected slice.
- Everything else is in one module.

## Test plan
All scenarios use WIDTH=6.
- 111000 accepted, out_ready=1 -> out_data=101000, out_cnt=1, out_valid at the 4th edge after accept, in_ready back to 1 one cycle after the DONE handshake.
- 111111 -> 101011, out_cnt=2. 111110 -> 101010, out_cnt=2. 000000 -> 000000, out_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles after out_valid -> outputs stable, in_ready=0, and an in_valid pulse during this time is ignored. Release -> IDLE next cycle.
- Back-to-back words 111000 then 011100, with in_valid held and out_ready=1 -> results 101000/cnt 1 then 010100/cnt 1, accepts 6 cycles apart.
- rst_n pulsed low during the 2nd SCAN cycle -> all outputs go to reset values asynchronously and out_valid never rises for that word. The next word decodes correctly.
- PATTERN_CHECK_EN defined: 101000 -> out_err=1 with out_data=101000. 111000 -> out_err=0.
